// File: rtl/arrow_pkg.sv
// Shared types and constants for the lane-arrow sprite and its shape helper.
package arrow_pkg;

  localparam int unsigned COORD_W = 11;

  // Arrow pointing directions (value of the DIR parameter)
  localparam int unsigned DIR_LEFT  = 0;
  localparam int unsigned DIR_RIGHT = 1;
  localparam int unsigned DIR_UP    = 2;
  localparam int unsigned DIR_DOWN  = 3;

  // Signed screen coordinate, one bit wider than the scan counters so edge sums never wrap
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FALL  = 2'd1,
    FLASH = 2'd2
  } state_t;

  // Absolute value of a signed coordinate
  function automatic coord_t abs_c(input coord_t a);
    return a[COORD_W-1] ? -a : a;
  endfunction

endpackage

// File: rtl/arrow_shape.sv
// Combinational arrow coverage test: is scan point (x, y) inside an arrow centred at (xc, yc)?
// Ports:
//   x, y       scan position
//   xc, yc     arrow centre
//   covered_c  point lies in the triangular head or the rectangular shaft
module arrow_shape
  import arrow_pkg::*;
#(
  parameter int unsigned DIR = DIR_LEFT,
  parameter int unsigned HW  = 15
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] xc,
  input  logic [9:0] yc,
  output logic       covered_c
);

  localparam coord_t HW_C     = coord_t'(HW);
  localparam coord_t NEG_HW_C = coord_t'(0) - coord_t'(HW);
  localparam coord_t SHAFT_C  = coord_t'(HW / 3);
  localparam coord_t ZERO_C   = coord_t'(0);

  coord_t dx;
  coord_t dy;
  coord_t u;
  coord_t v;
  coord_t av;
  logic   head;
  logic   shaft;

  // Rotate into a left-pointing local frame, then test head triangle and shaft bar
  always_comb begin
    dx = coord_t'({1'b0, x}) - coord_t'({1'b0, xc});
    dy = coord_t'({1'b0, y}) - coord_t'({1'b0, yc});
    case (DIR)
      DIR_RIGHT: begin u = -dx; v = dy; end
      DIR_UP:    begin u = dy;  v = dx; end
      DIR_DOWN:  begin u = -dy; v = dx; end
      default:   begin u = dx;  v = dy; end
    endcase
    av        = abs_c(v);
    head      = (u >= NEG_HW_C) && (u <= ZERO_C) && (av <= (u + HW_C));
    shaft     = (u > ZERO_C) && (u < HW_C) && (av < SHAFT_C);
    covered_c = head || shaft;
  end

endmodule

// File: rtl/arrow_sprite.sv
// Falling lane arrow: spawns at SPAWN_Y, drops STEP pixels per frame, is judged against
// the lane hit button around TARGET_Y, and flashes for FLASH_FRAMES frames after a hit.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_tick, spawn     sequencer pulses
//   hit_btn               player button level for this lane
//   x, y                  scan position
//   pixel, flash          registered sprite coverage and hit-colour select (1-cycle latency)
//   active                arrow is falling or flashing
//   hit_pulse, miss_pulse one-cycle judgement pulses
//   yc                    current centre y
module arrow_sprite
  import arrow_pkg::*;
#(
  parameter int unsigned DIR          = DIR_LEFT,
  parameter int unsigned IX           = 50,
  parameter int unsigned SPAWN_Y      = 20,
  parameter int unsigned TARGET_Y     = 400,
  parameter int unsigned HW           = 15,
  parameter int unsigned STEP         = 2,
  parameter int unsigned HIT_WIN      = 12,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       hit_btn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       pixel,
  output logic       flash,
  output logic       active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [9:0] yc
);

  localparam int unsigned CNT_W   = (FLASH_FRAMES < 2) ? 1 : $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_FRAMES);
  localparam logic [9:0]       SPAWN_C    = 10'(SPAWN_Y);
  localparam logic [9:0]       IX_C       = 10'(IX);
  localparam coord_t           TARGET_C   = coord_t'(TARGET_Y);
  localparam coord_t           WIN_C      = coord_t'(HIT_WIN);
  localparam coord_t           MISS_C     = coord_t'(TARGET_Y + HIT_WIN);
  localparam coord_t           STEP_C     = coord_t'(STEP);

  state_t           state_q, state_d;
  logic [9:0]       yc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q;
  logic             hit_d, miss_d;
  logic             hit_edge;
  logic             in_win;
  coord_t           yc_step;
  logic             covered_c;

  arrow_shape #(
    .DIR (DIR),
    .HW  (HW)
  ) u_shape (
    .x         (x),
    .y         (y),
    .xc        (IX_C),
    .yc        (yc),
    .covered_c (covered_c)
  );

  assign hit_edge = hit_btn && !hit_q;
  assign in_win   = abs_c(coord_t'({1'b0, yc}) - TARGET_C) <= WIN_C;
  assign yc_step  = coord_t'({1'b0, yc}) + STEP_C;

  // Next-state logic; a hit takes priority over both movement and miss
  always_comb begin
    state_d = state_q;
    yc_d    = yc;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn) begin
          yc_d    = SPAWN_C;
          state_d = FALL;
        end
      end
      FALL: begin
        if (hit_edge && in_win) begin
          hit_d   = 1'b1;
          cnt_d   = FLASH_INIT;
          state_d = FLASH;
        end else if (frame_tick) begin
          yc_d = yc_step[9:0];
          if (yc_step > MISS_C) begin
            miss_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; pixel/flash reflect the state seen with the sampled scan point
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      yc         <= SPAWN_C;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      pixel      <= 1'b0;
      flash      <= 1'b0;
      active     <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      yc         <= yc_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_btn;
      pixel      <= covered_c && (state_q != IDLE);
      flash      <= (state_q == FLASH);
      active     <= (state_d != IDLE);
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
    end
  end

endmodule
